// File: rtl/img_sram_arbiter.sv
// img_sram_arbiter
// Shares the single image SRAM port between three requesters (RX writer,
// convolution engine, TX reader) using registered round-robin arbitration
// with burst locking. Every grant is followed by exactly one TURN cycle.
//
// Optional feature macro: IMG_ARB_PREEMPT_EN
//   When defined, an 8-bit burst counter bounds the owner's tenure to
//   MAX_BURST cycles whenever another port is waiting.
//   When undefined, a grant lasts until the owner drops its request.

module img_sram_arbiter #(
  parameter int NREQ      = 3,
  parameter int MAX_BURST = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  output logic [NREQ-1:0]      gnt,
  input  logic [8*NREQ-1:0]    m_row,
  input  logic [8*NREQ-1:0]    m_col,
  input  logic [8*NREQ-1:0]    m_din,
  input  logic [NREQ-1:0]      m_write_en,
  input  logic [NREQ-1:0]      m_sense_en,
  output logic [7:0]           sram_row,
  output logic [7:0]           sram_col,
  output logic [7:0]           sram_din,
  output logic                 sram_write_en,
  output logic                 sram_sense_en,
  output logic [1:0]           owner,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;

  localparam logic [1:0] NO_OWNER = 2'd3;

  // Elaboration-time guard on the supported configuration.
  generate
    if (NREQ != 3) begin : g_bad_nreq
      $error("img_sram_arbiter: NREQ must be 3");
    end
    if (MAX_BURST < 2 || MAX_BURST > 255) begin : g_bad_burst
      $error("img_sram_arbiter: MAX_BURST must be in 2..255");
    end
  endgenerate

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [1:0]      owner_nxt;
  logic [1:0]      last;
  logic [1:0]      last_nxt;
  logic [1:0]      winner;
  logic            any_req;
  logic            owner_req;
  logic            preempt;

  // Round-robin successor: 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign any_req = |req;

  // Pick the first requesting port, searching from the one after the last winner.
  always_comb begin
    logic [1:0] c1;
    logic [1:0] c2;
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    winner = last;
    c1     = rr_next(last);
    c2     = rr_next(c1);
    if (req[c1])        winner = c1;
    else if (req[c2])   winner = c2;
    else                winner = last;
  end

  // Request bit of the current owner; zero when nobody owns the SRAM.
  always_comb begin
    owner_req = 1'b0;
    case (owner)
      2'd0:    owner_req = req[0];
      2'd1:    owner_req = req[1];
      2'd2:    owner_req = req[2];
      default: owner_req = 1'b0;
    endcase
  end

`ifdef IMG_ARB_PREEMPT_EN
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  logic [7:0] burst_cnt;

  // Count GRANT cycles; zero outside GRANT so each burst starts from 0, and
  // saturate so an uncontested owner keeps the grant indefinitely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= 8'd0;
    end else if (state != S_GRANT) begin
      burst_cnt <= 8'd0;
    end else if (burst_cnt != BURST_LAST) begin
      burst_cnt <= burst_cnt + 8'd1;
    end
  end

  assign preempt = (burst_cnt == BURST_LAST) && ((req & ~gnt) != '0);
`else
  assign preempt = 1'b0;
`endif

  // Next-state, grant and pointer logic. TURN arbitrates exactly like IDLE, so
  // a waiting port is granted on the edge that ends the TURN cycle.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    last_nxt  = last;
    case (state)
      S_IDLE, S_TURN: begin
        if (any_req) begin
          state_nxt = S_GRANT;
          gnt_nxt   = NREQ'(1) << winner;
          owner_nxt = winner;
          last_nxt  = winner;
        end else begin
          state_nxt = S_IDLE;
          gnt_nxt   = '0;
          owner_nxt = NO_OWNER;
        end
      end
      S_GRANT: begin
        if (!owner_req || preempt) begin
          state_nxt = S_TURN;
          gnt_nxt   = '0;
          owner_nxt = NO_OWNER;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        gnt_nxt   = '0;
        owner_nxt = NO_OWNER;
      end
    endcase
  end

  // Registered FSM state, grant, owner and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      gnt   <= '0;
      owner <= NO_OWNER;
      last  <= 2'd2;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state <= state_nxt;
      gnt   <= gnt_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  assign busy = (state != S_IDLE);

  // SRAM mux: OR of the granted port's fields; strobes also need the owner's
  // live request so the cycle in which req falls performs no access.
  always_comb begin
    sram_row      = 8'd0;
    sram_col      = 8'd0;
    sram_din      = 8'd0;
    sram_write_en = 1'b0;
    sram_sense_en = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sram_row      = sram_row | ({8{gnt[i]}} & m_row[8*i +: 8]);
      sram_col      = sram_col | ({8{gnt[i]}} & m_col[8*i +: 8]);
      sram_din      = sram_din | ({8{gnt[i]}} & m_din[8*i +: 8]);
      sram_write_en = sram_write_en | (gnt[i] & req[i] & m_write_en[i]);
      sram_sense_en = sram_sense_en | (gnt[i] & req[i] & m_sense_en[i]);
    end
  end

endmodule
